// File: rtl/ps2_kbd_led_tx.sv
// ps2_kbd_led_tx -- host-to-keyboard Set-LEDs transmitter.
//
// Sends 0xED followed by the LED mask byte through the PS/2 controller's
// command port. It watches the received-byte stream for ACK (0xFA) and
// Resend (0xFE), retries each byte up to MAX_RETRIES times, and reports the
// outcome as a one-cycle done or error pulse.
//
// Optional build macro: PS2_LED_REQ_QUEUE_EN
//   defined   - a led_req seen while busy is kept as one pending request (the
//               last one wins). It starts straight after the current
//               transaction finishes, and busy stays high in between.
//   undefined - a led_req seen while busy is dropped.

module ps2_kbd_led_tx #(
    parameter int unsigned ACK_TIMEOUT  = 2000000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter logic [7:0]  CMD_SET_LEDS = 8'hED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] cmd_byte,
    output logic       cmd_send,
    input  logic       cmd_sent,
    input  logic       cmd_timed_out,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    // Counter widths. Both are kept at least one bit wide for degenerate parameters.
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_SEND_CMD      = 3'd1;
    localparam logic [2:0] S_WAIT_ACK_CMD  = 3'd2;
    localparam logic [2:0] S_SEND_MASK     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK_MASK = 3'd4;

    logic [2:0]      state_q,    state_d;
    logic [7:0]      mask_q,     mask_d;
    logic [RT_W-1:0] retry_q,    retry_d;
    logic [TO_W-1:0] timeout_q,  timeout_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            error_q,    error_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic            cmd_send_q, cmd_send_d;

`ifdef PS2_LED_REQ_QUEUE_EN
    logic            pending_q,   pending_d;
    logic [2:0]      pend_mask_q, pend_mask_d;
`endif

    // Scratch flags that collect the outcome of the per-state decode.
    logic            retry_evt;
    logic            finish;
    logic [2:0]      resend_state;

    // Next-state decode: sequencing, the retry policy, and the end of a transaction.
    always_comb begin
        // NOTE: every value written below gets a default first, so no path through this block infers a latch.
        state_d      = state_q;
        mask_d       = mask_q;
        retry_d      = retry_q;
        timeout_d    = timeout_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_send_d   = cmd_send_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        retry_evt    = 1'b0;
        finish       = 1'b0;
        resend_state = state_q;
`ifdef PS2_LED_REQ_QUEUE_EN
        pending_d    = pending_q;
        pend_mask_d  = pend_mask_q;
        if (led_req && (state_q != S_IDLE)) begin
            pending_d   = 1'b1;
            pend_mask_d = led_mask;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (led_req) begin
                    mask_d  = {5'b0, led_mask};
                    retry_d = '0;
                    state_d = S_SEND_CMD;
                end
            end

            S_SEND_CMD, S_SEND_MASK: begin
                // cmd_send is raised only after a cycle low, so every attempt
                // shows the controller a fresh rising edge. The byte is loaded
                // on that same edge and then held.
                if (!cmd_send_q) begin
                    cmd_send_d = 1'b1;
                    cmd_byte_d = (state_q == S_SEND_CMD) ? CMD_SET_LEDS : mask_q;
                end else if (cmd_sent) begin
                    // cmd_sent takes priority when cmd_timed_out arrives in the same cycle.
                    cmd_send_d = 1'b0;
                    timeout_d  = '0;
                    state_d    = (state_q == S_SEND_CMD) ? S_WAIT_ACK_CMD : S_WAIT_ACK_MASK;
                end else if (cmd_timed_out) begin
                    retry_evt    = 1'b1;
                    resend_state = state_q;
                end
            end

            S_WAIT_ACK_CMD, S_WAIT_ACK_MASK: begin
                if (rx_valid && (rx_data == RESP_ACK)) begin
                    retry_d = '0;
                    if (state_q == S_WAIT_ACK_CMD) begin
                        state_d = S_SEND_MASK;
                    end else begin
                        done_d = 1'b1;
                        finish = 1'b1;
                    end
                end else if ((rx_valid && (rx_data == RESP_RESEND)) || (timeout_q == TO_LAST)) begin
                    retry_evt    = 1'b1;
                    resend_state = (state_q == S_WAIT_ACK_CMD) ? S_SEND_CMD : S_SEND_MASK;
                end else begin
                    // Stray scan codes fall through here and do not restart the count.
                    timeout_d = timeout_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A retry is either another attempt at the same byte or the final error.
        if (retry_evt) begin
            cmd_send_d = 1'b0;
            if (retry_q == RT_MAX) begin
                error_d = 1'b1;
                finish  = 1'b1;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = resend_state;
            end
        end

        // End of transaction. A queued request, if any, chains on directly.
        if (finish) begin
            cmd_send_d = 1'b0;
            state_d    = S_IDLE;
`ifdef PS2_LED_REQ_QUEUE_EN
            if (pending_q || led_req) begin
                state_d   = S_SEND_CMD;
                mask_d    = {5'b0, (led_req ? led_mask : pend_mask_q)};
                retry_d   = '0;
                pending_d = 1'b0;
            end
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous active-high reset. Reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state updates use non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= 8'h00;
            retry_q     <= '0;
            timeout_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_byte_q  <= 8'h00;
            cmd_send_q  <= 1'b0;
`ifdef PS2_LED_REQ_QUEUE_EN
            pending_q   <= 1'b0;
            pend_mask_q <= 3'b000;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            retry_q     <= retry_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_send_q  <= cmd_send_d;
`ifdef PS2_LED_REQ_QUEUE_EN
            pending_q   <= pending_d;
            pend_mask_q <= pend_mask_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cmd_byte = cmd_byte_q;
    assign cmd_send = cmd_send_q;

endmodule

// File: tb/tb_ps2_kbd_led_tx.sv
// tb_ps2_kbd_led_tx -- bench for ps2_kbd_led_tx.
// A controller/keyboard model answers each send according to a scripted
// outcome list. A transaction-level model turns that same list into the
// expected byte sequence and the expected result (done or error). One
// compare process checks the DUT outputs on every cycle.
// Honours PS2_LED_REQ_QUEUE_EN the same way as the design.
`timescale 1ns/1ps

module tb_ps2_kbd_led_tx;

    localparam int ACK_TIMEOUT = 100;
    localparam int MAX_RETRIES = 3;
    localparam int TXN_LIMIT   = 3000;

    // Possible outcomes of one transmission attempt.
    localparam int O_ACK    = 0;  // keyboard answers FA
    localparam int O_RESEND = 1;  // keyboard answers FE
    localparam int O_NORESP = 2;  // keyboard stays silent
    localparam int O_CTLTO  = 3;  // controller reports a send timeout

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       led_req;
    logic [2:0] led_mask;
    logic       busy, done, error;
    logic [7:0] cmd_byte;
    logic       cmd_send;
    logic       cmd_sent, cmd_timed_out;
    logic [7:0] rx_data;
    logic       rx_valid;

    ps2_kbd_led_tx #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRIES (MAX_RETRIES),
        .CMD_SET_LEDS(8'hED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .led_req      (led_req),
        .led_mask     (led_mask),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cmd_byte     (cmd_byte),
        .cmd_send     (cmd_send),
        .cmd_sent     (cmd_sent),
        .cmd_timed_out(cmd_timed_out),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Shared bench state.
    int         script_q[$];      // outcome for each upcoming attempt (empty => ACK)
    logic [7:0] stray_q[$];       // forced stray bytes for the next reply wait
    logic [7:0] log_q[$];         // every byte the DUT started sending
    int         gap_q[$];         // cycles from previous cmd_sent to each send start
    logic [7:0] exp_q[$];         // expected send sequence across the whole run
    int         send_pos = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         ctl_phase = 0;
    int         fix_sent_dly = -1;
    int         fix_reply_dly = -1;
    bit         rand_stray = 1'b0;
    logic [7:0] stray_tab [0:5] = '{8'hE0, 8'h6B, 8'h74, 8'hF0, 8'h1C, 8'hAA};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Transaction model: each byte is retransmitted until it is ACKed. The
    // (MAX_RETRIES+1)th non-ACK attempt on a byte ends the transaction with an error.
    function automatic bit model_txn(input logic [2:0] mask, input int scr[$]);
        logic [7:0] b [0:1];
        int k;
        int nfail;
        int o;
        bit acked;
        b[0] = 8'hED;
        b[1] = {5'b0, mask};
        k = 0;
        for (int i = 0; i < 2; i++) begin
            nfail = 0;
            acked = 1'b0;
            while (!acked) begin
                exp_q.push_back(b[i]);
                o = (k < scr.size()) ? scr[k] : O_ACK;
                k++;
                if (o == O_ACK) acked = 1'b1;
                else begin
                    nfail++;
                    if (nfail > MAX_RETRIES) return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    // Controller + keyboard model. Drives inputs on the falling edge.
    initial begin : ctl
        int cnt;
        int outcome;
        int cyc;
        int last_sent_cyc;
        cnt = 0; outcome = O_ACK; cyc = 0; last_sent_cyc = -100000;
        cmd_sent = 1'b0; cmd_timed_out = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            cmd_sent = 1'b0; cmd_timed_out = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
            if (reset) begin
                ctl_phase = 0;
            end else begin
                case (ctl_phase)
                    0: begin
                        if (cmd_send) begin
                            log_q.push_back(cmd_byte);
                            gap_q.push_back(cyc - last_sent_cyc);
                            outcome = (script_q.size() > 0) ? script_q.pop_front() : O_ACK;
                            cnt = (fix_sent_dly >= 0) ? fix_sent_dly : int'($urandom_range(0, 15));
                            ctl_phase = 1;
                        end else if (rand_stray && $urandom_range(0, 7) == 0) begin
                            rx_valid = 1'b1;
                            rx_data  = stray_tab[$urandom_range(0, 5)];
                        end
                    end
                    1: begin
                        if (cnt == 0) begin
                            if (outcome == O_CTLTO) begin
                                cmd_timed_out = 1'b1;
                                ctl_phase = 0;
                            end else begin
                                cmd_sent = 1'b1;
                                last_sent_cyc = cyc;
                                if (outcome == O_NORESP) ctl_phase = 0;
                                else begin
                                    cnt = (fix_reply_dly >= 0) ? fix_reply_dly : int'($urandom_range(3, 60));
                                    ctl_phase = 2;
                                end
                            end
                        end else begin
                            cnt--;
                            if (rand_stray && $urandom_range(0, 7) == 0) begin
                                rx_valid = 1'b1;
                                rx_data  = stray_tab[$urandom_range(0, 5)];
                            end
                        end
                    end
                    default: begin
                        if (cnt == 0) begin
                            rx_valid = 1'b1;
                            rx_data  = (outcome == O_ACK) ? 8'hFA : 8'hFE;
                            ctl_phase = 0;
                        end else begin
                            cnt--;
                            if (stray_q.size() > 0) begin
                                rx_valid = 1'b1;
                                rx_data  = stray_q.pop_front();
                            end else if (rand_stray && $urandom_range(0, 7) == 0) begin
                                rx_valid = 1'b1;
                                rx_data  = stray_tab[$urandom_range(0, 5)];
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle compare against the expected send sequence and output invariants.
    initial begin : cmp
        logic       prev_send;
        logic [7:0] prev_byte;
        prev_send = 1'b0;
        prev_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cmd_send && !prev_send) begin
                    if (send_pos < exp_q.size()) check("send_byte", 32'(cmd_byte), 32'(exp_q[send_pos]));
                    else check("unexpected_send", 32'(cmd_byte), 32'hFFFF_FFFF);
                    send_pos++;
                end
                if (cmd_send && prev_send) check("byte_stable", 32'(cmd_byte), 32'(prev_byte));
                check("send_implies_busy", 32'(!cmd_send || busy), 32'd1);
                check("done_error_excl", 32'(done & error), 32'd0);
`ifndef PS2_LED_REQ_QUEUE_EN
                if (done || error) check("busy_drop_at_end", 32'(busy), 32'd0);
`endif
                if (done) done_cnt++;
                if (error) err_cnt++;
            end
            prev_send = reset ? 1'b0 : cmd_send;
            prev_byte = cmd_byte;
        end
    end

    task automatic issue_req(input logic [2:0] mask);
        step();
        led_req  = 1'b1;
        led_mask = mask;
        step();
        led_req  = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] mask, input int scr[$], input string tag);
        int d0, e0, p0, n;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; p0 = exp_q.size();
        script_q = scr;
        ok = model_txn(mask, scr);
        issue_req(mask);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < TXN_LIMIT) begin
            step();
            n++;
        end
        check({tag, "_finished"}, 32'(n < TXN_LIMIT), 32'd1);
        check({tag, "_busy_at_end"}, 32'(busy), 32'd0);
        repeat (2) step();
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
        check({tag, "_sends"}, 32'(send_pos - p0), 32'(exp_q.size() - p0));
        check({tag, "_idle_send"}, 32'(cmd_send), 32'd0);
        script_q.delete();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int scr[$];
        int none_q[$];
        int d0, e0, low, n, target, len, r;
        logic [2:0] m;
        led_req = 1'b0;
        led_mask = 3'b000;

        // Reset values.
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cmd_send", 32'(cmd_send), 32'd0);
        check("rst_cmd_byte", 32'(cmd_byte), 32'h00);
        reset = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Basic transaction: send delay 10, reply delay 50.
        fix_sent_dly = 9; fix_reply_dly = 49;
        log_q.delete();
        run_txn(3'b100, none_q, "t1");
        check("t1_nlog", 32'(log_q.size()), 32'd2);
        check("t1_b0", 32'(log_q[0]), 32'hED);
        check("t1_b1", 32'(log_q[1]), 32'h04);

        // The first ED gets a Resend.
        log_q.delete(); scr.delete(); scr.push_back(O_RESEND);
        run_txn(3'b100, scr, "t2");
        check("t2_nlog", 32'(log_q.size()), 32'd3);
        check("t2_b0", 32'(log_q[0]), 32'hED);
        check("t2_b1", 32'(log_q[1]), 32'hED);
        check("t2_b2", 32'(log_q[2]), 32'h04);

        // The keyboard never answers: four attempts, then an error.
        log_q.delete(); gap_q.delete(); scr.delete();
        repeat (4) scr.push_back(O_NORESP);
        d0 = err_cnt;
        run_txn(3'b100, scr, "t3");
        check("t3_nlog", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_byte", 32'(log_q[i]), 32'hED);
        for (int i = 1; i < 4; i++)
            check("t3_gap", 32'(gap_q[i] >= ACK_TIMEOUT + 1 && gap_q[i] <= ACK_TIMEOUT + 3), 32'd1);
        check("t3_error", 32'(err_cnt - d0), 32'd1);

        // Stray scan codes during WAIT_ACK_CMD are ignored.
        log_q.delete();
        stray_q.push_back(8'hE0); stray_q.push_back(8'h6B);
        run_txn(3'b100, none_q, "t4");
        check("t4_strays_used", 32'(stray_q.size()), 32'd0);
        check("t4_nlog", 32'(log_q.size()), 32'd2);
        check("t4_b1", 32'(log_q[1]), 32'h04);

        // Reset during WAIT_ACK_MASK.
        log_q.delete();
        d0 = done_cnt; e0 = err_cnt;
        void'(model_txn(3'b101, none_q));
        issue_req(3'b101);
        n = 0;
        while (!(log_q.size() == 2 && ctl_phase == 2) && n < TXN_LIMIT) begin
            step();
            n++;
        end
        check("t5_reached_wait_mask", 32'(n < TXN_LIMIT), 32'd1);
        reset = 1'b1;
        step();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cmd_send", 32'(cmd_send), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (3) step();
        check("t5_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        log_q.delete();
        run_txn(3'b011, none_q, "t5b");
        check("t5b_b0", 32'(log_q[0]), 32'hED);
        check("t5b_b1", 32'(log_q[1]), 32'h03);

        // led_req while busy.
        log_q.delete();
        d0 = done_cnt;
        void'(model_txn(3'b110, none_q));
`ifdef PS2_LED_REQ_QUEUE_EN
        void'(model_txn(3'b010, none_q));
        target = d0 + 2;
`else
        target = d0 + 1;
`endif
        issue_req(3'b110);
        repeat (5) step();
        check("t6_busy_before_req", 32'(busy), 32'd1);
        issue_req(3'b001);
        repeat (20) step();
        issue_req(3'b010);
        low = 0; n = 0;
        while (done_cnt < target && n < TXN_LIMIT) begin
            if (!busy) low++;
            step();
            n++;
        end
        check("t6_finished", 32'(n < TXN_LIMIT), 32'd1);
        check("t6_busy_held", 32'(low), 32'd0);
        repeat (300) step();
        check("t6_dones", 32'(done_cnt - d0), 32'(target - d0));
        check("t6_sends", 32'(send_pos), 32'(exp_q.size()));
        check("t6_b1", 32'(log_q[1]), 32'h06);
`ifdef PS2_LED_REQ_QUEUE_EN
        check("t6_nlog", 32'(log_q.size()), 32'd4);
        check("t6_b2", 32'(log_q[2]), 32'hED);
        check("t6_b3", 32'(log_q[3]), 32'h02);
`else
        check("t6_nlog", 32'(log_q.size()), 32'd2);
`endif
        check("t6_idle", 32'(busy), 32'd0);

        // Randomised transactions against the model.
        fix_sent_dly = -1; fix_reply_dly = -1; rand_stray = 1'b1;
        for (int t = 0; t < 40; t++) begin
            scr.delete();
            len = $urandom_range(0, 8);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 99);
                if (r < 60) scr.push_back(O_ACK);
                else if (r < 80) scr.push_back(O_RESEND);
                else if (r < 88) scr.push_back(O_NORESP);
                else scr.push_back(O_CTLTO);
            end
            m = 3'($urandom_range(0, 7));
            run_txn(m, scr, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
